// File: rtl/bht_mt_2bit.sv
// Multithreaded branch history table of 2-bit saturating counters with a
// one-entry-per-cycle flush walker. Define BHT_BYPASS_EN to forward stage-2 updates to lookups.
module bht_mt_2bit #(
  parameter int unsigned VLEN       = 64,
  parameter int unsigned NR_ENTRIES = 64,
  parameter int unsigned NR_THREADS = 2,
  parameter int unsigned TID_W      = (NR_THREADS > 1) ? $clog2(NR_THREADS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_bht_i,
  input  logic             lookup_valid_i,
  input  logic [VLEN-1:0]  lookup_pc_i,
  input  logic [TID_W-1:0] lookup_thread_i,
  output logic             pred_valid_o,
  output logic             pred_taken_o,
  input  logic             resolve_valid_i,
  input  logic             resolve_is_branch_i,
  input  logic             resolve_taken_i,
  input  logic [VLEN-1:0]  resolve_pc_i,
  input  logic [TID_W-1:0] resolve_thread_i,
  output logic             busy_o
);

  localparam int unsigned IDX_W = $clog2(NR_ENTRIES);
  localparam int unsigned TOTAL = NR_ENTRIES * NR_THREADS;
  localparam int unsigned AW    = $clog2(TOTAL);
  localparam logic [AW-1:0] LAST_IDX = AW'(TOTAL - 1);

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] walk_q, walk_d;
  logic [1:0]    cnt_q [TOTAL];

  logic [AW-1:0] lk_idx, rs_idx;
  logic          idle, lk_accept, rs_accept;

  logic          upd_valid_q, upd_valid_d;
  logic [AW-1:0] upd_idx_q;
  logic          upd_taken_q;
  logic [1:0]    upd_cur, upd_new;

  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [1:0]    wr_data;

  logic [1:0]    lk_cnt;
  logic          pred_valid_q, pred_taken_q;
  logic          unused_bits;

  // Bit 0 of the PC is ignored because branches may sit on compressed 16-bit boundaries.
  generate
    if (NR_THREADS > 1) begin : g_mt_idx
      assign lk_idx = {lookup_thread_i, lookup_pc_i[IDX_W:1]};
      assign rs_idx = {resolve_thread_i, resolve_pc_i[IDX_W:1]};
    end else begin : g_st_idx
      assign lk_idx = lookup_pc_i[IDX_W:1];
      assign rs_idx = resolve_pc_i[IDX_W:1];
    end
  endgenerate

  assign unused_bits = ^{lookup_pc_i[VLEN-1:IDX_W+1], lookup_pc_i[0],
                         resolve_pc_i[VLEN-1:IDX_W+1], resolve_pc_i[0],
                         lookup_thread_i, resolve_thread_i};

  assign idle        = (state_q == IDLE);
  assign lk_accept   = lookup_valid_i && idle && !flush_bht_i;
  assign rs_accept   = resolve_valid_i && resolve_is_branch_i && idle && !flush_bht_i;
  assign upd_valid_d = rs_accept;

  // Stage 2 reads the array after the previous write, so same-index updates chain cleanly.
  assign upd_cur = cnt_q[upd_idx_q];
  always_comb begin
    upd_new = upd_cur;
    if (upd_taken_q) begin
      if (upd_cur != 2'd3) upd_new = upd_cur + 2'd1;
    end else begin
      if (upd_cur != 2'd0) upd_new = upd_cur - 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    walk_d  = walk_q;
    wr_en   = 1'b0;
    wr_idx  = upd_idx_q;
    wr_data = upd_new;
    case (state_q)
      IDLE: begin
        if (flush_bht_i) begin
          state_d = FLUSH;
          walk_d  = '0;
        end else if (upd_valid_q) begin
          wr_en = 1'b1;
        end
      end
      FLUSH: begin
        wr_en   = 1'b1;
        wr_idx  = walk_q;
        wr_data = 2'b01;
        if (flush_bht_i) begin
          walk_d = '0;
        end else if (walk_q == LAST_IDX) begin
          state_d = IDLE;
          walk_d  = '0;
        end else begin
          walk_d = walk_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        walk_d  = '0;
      end
    endcase
  end

`ifdef BHT_BYPASS_EN
  assign lk_cnt = (upd_valid_q && (upd_idx_q == lk_idx)) ? upd_new : cnt_q[lk_idx];
`else
  assign lk_cnt = cnt_q[lk_idx];
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < TOTAL; i++) cnt_q[i] <= 2'b01;
    end else if (wr_en) begin
      cnt_q[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      walk_q       <= '0;
      upd_valid_q  <= 1'b0;
      upd_idx_q    <= '0;
      upd_taken_q  <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      walk_q       <= walk_d;
      upd_valid_q  <= upd_valid_d;
      pred_valid_q <= lk_accept;
      if (rs_accept) begin
        upd_idx_q   <= rs_idx;
        upd_taken_q <= resolve_taken_i;
      end
      if (lk_accept) pred_taken_q <= lk_cnt[1];
    end
  end

  assign pred_valid_o = pred_valid_q;
  assign pred_taken_o = pred_taken_q;
  assign busy_o       = (state_q == FLUSH);

endmodule

// File: tb/tb_bht_mt_2bit.sv
// Self-checking bench for bht_mt_2bit: directed scenarios plus randomized traffic
// checked against a counter-array model with one-cycle update visibility delay.
module tb_bht_mt_2bit;
  localparam int VLEN = 64;
  localparam int NE   = 64;
  localparam int NT   = 2;
  localparam int TW   = 1;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            flush_bht_i = 1'b0;
  logic            lookup_valid_i = 1'b0;
  logic [VLEN-1:0] lookup_pc_i = '0;
  logic [TW-1:0]   lookup_thread_i = '0;
  logic            pred_valid_o, pred_taken_o;
  logic            resolve_valid_i = 1'b0;
  logic            resolve_is_branch_i = 1'b0;
  logic            resolve_taken_i = 1'b0;
  logic [VLEN-1:0] resolve_pc_i = '0;
  logic [TW-1:0]   resolve_thread_i = '0;
  logic            busy_o;

  int n_cmp  = 0;
  int n_fail = 0;

  bht_mt_2bit #(.VLEN(VLEN), .NR_ENTRIES(NE), .NR_THREADS(NT), .TID_W(TW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_bht_i(flush_bht_i),
    .lookup_valid_i(lookup_valid_i), .lookup_pc_i(lookup_pc_i),
    .lookup_thread_i(lookup_thread_i), .pred_valid_o(pred_valid_o),
    .pred_taken_o(pred_taken_o), .resolve_valid_i(resolve_valid_i),
    .resolve_is_branch_i(resolve_is_branch_i), .resolve_taken_i(resolve_taken_i),
    .resolve_pc_i(resolve_pc_i), .resolve_thread_i(resolve_thread_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int step_cnt(input int c, input bit taken);
    if (taken) return (c == 3) ? 3 : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
  endtask

  task automatic do_resolve(input logic [63:0] pc, input int thr, input bit br, input bit tk);
    resolve_valid_i = 1'b1; resolve_is_branch_i = br; resolve_taken_i = tk;
    resolve_pc_i = pc; resolve_thread_i = TW'(thr);
    tick();
    resolve_valid_i = 1'b0;
    $display("resolve pc=%h thr=%0d br=%0d taken=%0d", pc, thr, br, tk);
  endtask

  task automatic do_lookup(input logic [63:0] pc, input int thr, output logic v, output logic t);
    lookup_valid_i = 1'b1; lookup_pc_i = pc; lookup_thread_i = TW'(thr);
    tick();
    lookup_valid_i = 1'b0;
    v = pred_valid_o; t = pred_taken_o;
    $display("lookup  pc=%h thr=%0d -> valid=%0b taken=%0b", pc, thr, v, t);
  endtask

  task automatic test_reset();
    logic v, t;
    rst_i = 1'b1;
    tick();
    n_cmp++;
    if ({pred_valid_o, pred_taken_o, busy_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset_outputs got=%b exp=000", {pred_valid_o, pred_taken_o, busy_o});
    end
    rst_i = 1'b0;
    tick();
    do_lookup(64'h8000_0000, 0, v, t);
    n_cmp++;
    if ({v, t} !== 2'b10) begin n_fail++; $display("FAIL first_lookup got=%b exp=10", {v, t}); end
    tick();
    n_cmp++;
    if (pred_valid_o !== 1'b0) begin n_fail++; $display("FAIL valid_drops got=%b exp=0", pred_valid_o); end
  endtask

  task automatic test_training();
    logic v, t;
    for (int i = 0; i < 3; i++) do_resolve(64'h8000_0010, 1, 1, 1);
    tick();
    do_lookup(64'h8000_0010, 1, v, t);
    n_cmp++;
    if ({v, t} !== 2'b11) begin n_fail++; $display("FAIL train_sat3 got=%b exp=11", {v, t}); end
    do_resolve(64'h8000_0010, 1, 1, 0);
    tick();
    do_lookup(64'h8000_0010, 1, v, t);
    n_cmp++;
    if ({v, t} !== 2'b11) begin n_fail++; $display("FAIL train_cnt2 got=%b exp=11", {v, t}); end
    do_resolve(64'h8000_0010, 1, 1, 0);
    tick();
    do_lookup(64'h8000_0010, 1, v, t);
    n_cmp++;
    if ({v, t} !== 2'b10) begin n_fail++; $display("FAIL train_cnt1 got=%b exp=10", {v, t}); end
    // Saturate at zero, then one taken only reaches 1 (still not-taken).
    for (int i = 0; i < 3; i++) do_resolve(64'h0000_0300, 0, 1, 0);
    do_resolve(64'h0000_0300, 0, 1, 1);
    tick();
    do_lookup(64'h0000_0300, 0, v, t);
    n_cmp++;
    if ({v, t} !== 2'b10) begin n_fail++; $display("FAIL sat_zero got=%b exp=10", {v, t}); end
  endtask

  task automatic test_thread_isolation();
    logic v, t;
    do_resolve(64'h40, 0, 1, 1);
    do_resolve(64'h40, 0, 1, 1);
    tick();
    do_lookup(64'h40, 1, v, t);
    n_cmp++;
    if ({v, t} !== 2'b10) begin n_fail++; $display("FAIL iso_thr1 got=%b exp=10", {v, t}); end
    do_lookup(64'h41, 0, v, t);
    n_cmp++;
    if ({v, t} !== 2'b11) begin n_fail++; $display("FAIL iso_thr0 got=%b exp=11", {v, t}); end
  endtask

  task automatic test_non_branch();
    logic v, t;
    for (int i = 0; i < 3; i++) do_resolve(64'h120, 0, 0, 1);
    tick();
    do_lookup(64'h120, 0, v, t);
    n_cmp++;
    if ({v, t} !== 2'b10) begin n_fail++; $display("FAIL jalr_ignored got=%b exp=10", {v, t}); end
  endtask

  task automatic test_flush();
    logic v, t;
    int n;
    // Entry is at 1 after training; two taken resolves bring it to 3.
    do_resolve(64'h8000_0010, 1, 1, 1);
    do_resolve(64'h8000_0010, 1, 1, 1);
    tick();
    do_lookup(64'h8000_0010, 1, v, t);
    n_cmp++;
    if ({v, t} !== 2'b11) begin n_fail++; $display("FAIL pre_flush got=%b exp=11", {v, t}); end
    flush_bht_i = 1'b1; lookup_valid_i = 1'b1; lookup_pc_i = 64'h8000_0010; lookup_thread_i = 1'b1;
    resolve_valid_i = 1'b1; resolve_is_branch_i = 1'b1; resolve_taken_i = 1'b1;
    resolve_pc_i = 64'h8000_0010; resolve_thread_i = 1'b1;
    tick();
    flush_bht_i = 1'b0; resolve_valid_i = 1'b0;
    n_cmp++;
    if (pred_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_cycle_lookup got=%b exp=0", pred_valid_o); end
    n = 0;
    while (busy_o === 1'b1 && n < 300) begin
      n++;
      tick();
      n_cmp++;
      if (pred_valid_o !== 1'b0) begin n_fail++; $display("FAIL walk_lookup cyc=%0d got=%b exp=0", n, pred_valid_o); end
    end
    lookup_valid_i = 1'b0;
    $display("flush walk busy cycles=%0d", n);
    n_cmp++;
    if (n !== NE * NT) begin n_fail++; $display("FAIL busy_len got=%0d exp=%0d", n, NE * NT); end
    do_lookup(64'h8000_0010, 1, v, t);
    n_cmp++;
    if ({v, t} !== 2'b10) begin n_fail++; $display("FAIL post_flush got=%b exp=10", {v, t}); end
    do_lookup(64'h40, 0, v, t);
    n_cmp++;
    if ({v, t} !== 2'b10) begin n_fail++; $display("FAIL post_flush_thr0 got=%b exp=10", {v, t}); end
    // Restart the walk partway through.
    flush_bht_i = 1'b1; tick(); flush_bht_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    flush_bht_i = 1'b1; tick(); flush_bht_i = 1'b0;
    n = 0;
    while (busy_o === 1'b1 && n < 300) begin n++; tick(); end
    $display("restarted walk busy cycles=%0d", n);
    n_cmp++;
    if (n !== NE * NT) begin n_fail++; $display("FAIL restart_len got=%0d exp=%0d", n, NE * NT); end
  endtask

  task automatic test_reset_mid_walk();
    logic v, t;
    // Last index (thread 1, pc index 63) is the final entry the walk reaches.
    do_resolve(64'h7E, 1, 1, 1);
    do_resolve(64'h7E, 1, 1, 1);
    flush_bht_i = 1'b1; tick(); flush_bht_i = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    rst_i = 1'b1;
    #1;
    n_cmp++;
    if ({busy_o, pred_valid_o} !== 2'b00) begin n_fail++; $display("FAIL async_rst got=%b exp=00", {busy_o, pred_valid_o}); end
    tick();
    rst_i = 1'b0;
    do_lookup(64'h7E, 1, v, t);
    n_cmp++;
    if ({v, t} !== 2'b10) begin n_fail++; $display("FAIL rst_counters got=%b exp=10", {v, t}); end
  endtask

  task automatic test_bypass();
    logic v, t;
    logic exp_t;
`ifdef BHT_BYPASS_EN
    exp_t = 1'b1;
`else
    exp_t = 1'b0;
`endif
    do_reset();
    do_resolve(64'h200, 0, 1, 1);
    do_lookup(64'h200, 0, v, t);
    n_cmp++;
    if ({v, t} !== {1'b1, exp_t}) begin n_fail++; $display("FAIL bypass_t1 got=%b exp=%b", {v, t}, {1'b1, exp_t}); end
    do_lookup(64'h200, 0, v, t);
    n_cmp++;
    if ({v, t} !== 2'b11) begin n_fail++; $display("FAIL bypass_t2 got=%b exp=11", {v, t}); end
  endtask

  task automatic test_random();
    int model [NT][NE];
    bit pend_v;
    int pend_t, pend_i;
    bit pend_tk;
    bit lv, rv, br, tk;
    int lt, li, rt, ri, c;
    logic exp_tk_hold;
    logic [63:0] pc;
    do_reset();
    for (int a = 0; a < NT; a++) for (int b = 0; b < NE; b++) model[a][b] = 1;
    pend_v = 0; pend_t = 0; pend_i = 0; pend_tk = 0;
    exp_tk_hold = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      lv = ($urandom_range(0, 1) == 1);
      rv = ($urandom_range(0, 2) != 0);
      br = ($urandom_range(0, 3) != 0);
      tk = ($urandom_range(0, 2) != 0);
      lt = $urandom_range(0, NT - 1);
      li = $urandom_range(0, 7);
      rt = $urandom_range(0, NT - 1);
      ri = $urandom_range(0, 7);
      pc = {32'($urandom), 25'd0, 6'(li), 1'($urandom_range(0, 1))};
      lookup_valid_i = lv; lookup_pc_i = pc; lookup_thread_i = TW'(lt);
      pc = {32'($urandom), 25'd0, 6'(ri), 1'($urandom_range(0, 1))};
      resolve_valid_i = rv; resolve_is_branch_i = br; resolve_taken_i = tk;
      resolve_pc_i = pc; resolve_thread_i = TW'(rt);
      if (lv) begin
        c = model[lt][li];
`ifdef BHT_BYPASS_EN
        if (pend_v && pend_t == lt && pend_i == li) c = step_cnt(c, pend_tk);
`endif
        exp_tk_hold = (c >= 2);
      end
      tick();
      $display("rand cyc=%0d lk=%0b t%0d/i%0d rs=%0b br=%0b tk=%0b t%0d/i%0d -> v=%0b p=%0b",
               cyc, lv, lt, li, rv, br, tk, rt, ri, pred_valid_o, pred_taken_o);
      n_cmp++;
      if (pred_valid_o !== lv) begin n_fail++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, pred_valid_o, lv); end
      n_cmp++;
      if (pred_taken_o !== exp_tk_hold) begin n_fail++; $display("FAIL rand_taken cyc=%0d got=%b exp=%b", cyc, pred_taken_o, exp_tk_hold); end
      if (pend_v) model[pend_t][pend_i] = step_cnt(model[pend_t][pend_i], pend_tk);
      pend_v = rv && br; pend_t = rt; pend_i = ri; pend_tk = tk;
    end
    lookup_valid_i = 1'b0; resolve_valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_training();
    test_thread_isolation();
    test_non_branch();
    test_flush();
    test_reset_mid_walk();
    test_bypass();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
